// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C register target with oversampled bus inputs and a local register bank
// Answers device address, register pointer, then burst writes or burst reads; never stretches SCL.
module i2c_target #(
  parameter int                       DATA_WIDTH     = 8,
  parameter int                       REGISTER_WIDTH = 8,
  parameter int                       ADDRESS_WIDTH  = 7,
  parameter logic [ADDRESS_WIDTH-1:0] DEVICE_ADDRESS = 7'h11,
  parameter int                       REGISTER_COUNT = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      external_serial_clock,
  inout  wire                       external_serial_data,
  input  logic [REGISTER_WIDTH-1:0] host_read_address,
  output logic [DATA_WIDTH-1:0]     host_read_data,
  output logic                      write_strobe,
  output logic [REGISTER_WIDTH-1:0] write_register_address,
  output logic [DATA_WIDTH-1:0]     write_data,
  output logic                      busy
);
  localparam int INDEX_WIDTH = $clog2(REGISTER_COUNT);
  localparam logic [REGISTER_WIDTH:0] REGISTER_LIMIT = (REGISTER_WIDTH+1)'(REGISTER_COUNT);

  typedef enum logic [3:0] {
    S_IDLE, S_DEVICE_ADDRESS, S_ADDRESS_ACK, S_REGISTER_ADDRESS, S_REGISTER_ACK,
    S_WRITE_DATA, S_WRITE_ACK, S_READ_DATA, S_READ_ACK, S_IGNORE
  } state_t;

  state_t                    state, next_state;
  logic                      scl_meta, scl_sync, scl_prev;
  logic                      sda_meta, sda_sync, sda_prev;
  logic                      start_event, stop_event, scl_rise, scl_fall;
  logic [DATA_WIDTH-1:0]     shift;
  logic [3:0]                bit_count;
  logic [REGISTER_WIDTH-1:0] pointer;
  logic                      sda_low;
  logic [DATA_WIDTH-1:0]     bank [REGISTER_COUNT];
  logic                      pointer_in_range, address_match, byte_done;
  logic [DATA_WIDTH-1:0]     read_byte;

  assign external_serial_data = sda_low ? 1'b0 : 1'bz;

  assign pointer_in_range = {1'b0, pointer} < REGISTER_LIMIT;
  assign read_byte        = pointer_in_range ? bank[pointer[INDEX_WIDTH-1:0]] : '0;
  assign host_read_data   = ({1'b0, host_read_address} < REGISTER_LIMIT)
                          ? bank[host_read_address[INDEX_WIDTH-1:0]] : '0;
  assign address_match    = shift[DATA_WIDTH-1 -: ADDRESS_WIDTH] == DEVICE_ADDRESS;
  assign byte_done        = scl_fall && (bit_count == 4'd8);

  // Synchronizers idle high so leaving reset on a quiet bus decodes no events.
  always_ff @(posedge clock) begin
    if (reset) begin
      {scl_meta, scl_sync, scl_prev} <= 3'b111;
      {sda_meta, sda_sync, sda_prev} <= 3'b111;
      {start_event, stop_event, scl_rise, scl_fall} <= 4'b0000;
    end else begin
      scl_meta    <= external_serial_clock;
      scl_sync    <= scl_meta;
      scl_prev    <= scl_sync;
      sda_meta    <= external_serial_data;
      sda_sync    <= sda_meta;
      sda_prev    <= sda_sync;
      start_event <= scl_sync && scl_prev && sda_prev && !sda_sync;
      stop_event  <= scl_sync && scl_prev && !sda_prev && sda_sync;
      scl_rise    <= scl_sync && !scl_prev;
      scl_fall    <= !scl_sync && scl_prev;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (start_event)     next_state = S_DEVICE_ADDRESS;
    else if (stop_event) next_state = S_IDLE;
    else begin
      case (state)
        S_DEVICE_ADDRESS:   if (byte_done) next_state = address_match ? S_ADDRESS_ACK : S_IGNORE;
        S_ADDRESS_ACK:      if (scl_fall) next_state = shift[0] ? S_READ_DATA : S_REGISTER_ADDRESS;
        S_REGISTER_ADDRESS: if (byte_done) next_state = S_REGISTER_ACK;
        S_REGISTER_ACK:     if (scl_fall) next_state = S_WRITE_DATA;
        S_WRITE_DATA:       if (byte_done) next_state = S_WRITE_ACK;
        S_WRITE_ACK:        if (scl_fall) next_state = S_WRITE_DATA;
        S_READ_DATA:        if (byte_done) next_state = S_READ_ACK;
        S_READ_ACK: begin
          if (scl_rise && sda_prev) next_state = S_IGNORE;
          else if (scl_fall)        next_state = S_READ_DATA;
        end
        default: next_state = state;
      endcase
    end
  end

  always_comb begin
    busy = (state != S_IDLE) && (state != S_IGNORE);
  end

  // bit_count counts bits shifted in while receiving, and bits already driven while sending.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift                  <= '0;
      bit_count              <= '0;
      pointer                <= '0;
      sda_low                <= 1'b0;
      write_strobe           <= 1'b0;
      write_register_address <= '0;
      write_data             <= '0;
      for (int i = 0; i < REGISTER_COUNT; i++) bank[i] <= '0;
    end else begin
      write_strobe <= 1'b0;
      if (start_event) begin
        sda_low   <= 1'b0;
        bit_count <= '0;
      end else if (stop_event) begin
        sda_low <= 1'b0;
      end else begin
        case (state)
          S_DEVICE_ADDRESS, S_REGISTER_ADDRESS, S_WRITE_DATA: begin
            if (scl_rise) begin
              shift     <= {shift[DATA_WIDTH-2:0], sda_prev};
              bit_count <= bit_count + 4'd1;
            end else if (byte_done) begin
              bit_count <= '0;
              sda_low   <= (state == S_DEVICE_ADDRESS) ? address_match : 1'b1;
              if (state == S_REGISTER_ADDRESS) pointer <= shift;
              if (state == S_WRITE_DATA) begin
                if (pointer_in_range) bank[pointer[INDEX_WIDTH-1:0]] <= shift;
                write_strobe           <= 1'b1;
                write_register_address <= pointer;
                write_data             <= shift;
                pointer                <= pointer + 1'b1;
              end
            end
          end
          S_ADDRESS_ACK, S_REGISTER_ACK, S_WRITE_ACK: begin
            if (scl_fall) begin
              bit_count <= '0;
              sda_low   <= 1'b0;
              if (state == S_ADDRESS_ACK && shift[0]) begin
                shift     <= read_byte;
                sda_low   <= !read_byte[DATA_WIDTH-1];
                bit_count <= 4'd1;
              end
            end
          end
          S_READ_DATA: begin
            if (byte_done) begin
              sda_low <= 1'b0;
            end else if (scl_fall) begin
              shift     <= {shift[DATA_WIDTH-2:0], 1'b0};
              sda_low   <= !shift[DATA_WIDTH-2];
              bit_count <= bit_count + 4'd1;
            end
          end
          S_READ_ACK: begin
            if (scl_rise) begin
              pointer <= pointer + 1'b1;
            end else if (scl_fall) begin
              shift     <= read_byte;
              sda_low   <= !read_byte[DATA_WIDTH-1];
              bit_count <= 4'd1;
            end
          end
          default: sda_low <= 1'b0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - randomized bench for i2c_target against a transaction-level register model
module tb_i2c_target;
  logic       clock = 1'b0;
  logic       reset;
  logic       scl;
  logic       m_low;
  wire        sda_line;
  logic [7:0] host_read_address;
  logic [7:0] host_read_data;
  logic       write_strobe;
  logic [7:0] write_register_address;
  logic [7:0] write_data;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [7:0]  model_bank [16];
  logic [7:0]  model_ptr;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic        target_low_seen;

  assign sda_line = m_low ? 1'b0 : 1'bz;
  pullup (sda_line);

  i2c_target dut (
    .clock                  (clock),
    .reset                  (reset),
    .external_serial_clock  (scl),
    .external_serial_data   (sda_line),
    .host_read_address      (host_read_address),
    .host_read_data         (host_read_data),
    .write_strobe           (write_strobe),
    .write_register_address (write_register_address),
    .write_data             (write_data),
    .busy                   (busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (write_strobe === 1'b1) got_q.push_back({write_register_address, write_data});
    if (!m_low && sda_line === 1'b0) target_low_seen = 1'b1;
  end

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) model_bank[i] = 8'h00;
    model_ptr = 8'h00;
  endfunction

  function automatic void model_write(input logic [7:0] d);
    if (model_ptr < 8'd16) model_bank[model_ptr[3:0]] = d;
    exp_q.push_back({model_ptr, d});
    model_ptr = model_ptr + 8'd1;
  endfunction

  function automatic logic [7:0] model_read();
    logic [7:0] v;
    v = (model_ptr < 8'd16) ? model_bank[model_ptr[3:0]] : 8'h00;
    model_ptr = model_ptr + 8'd1;
    return v;
  endfunction

  function automatic logic [7:0] model_host(input logic [7:0] a);
    return (a < 8'd16) ? model_bank[a[3:0]] : 8'h00;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clock_bit(input logic v, output logic s);
    m_low = ~v;
    wait_clk(5);
    scl = 1'b1;
    wait_clk(5);
    s = sda_line;
    wait_clk(5);
    scl = 1'b0;
    wait_clk(5);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] b);
    logic s;
    b = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(~ack, s);
  endtask

  task automatic bus_start();
    m_low = 1'b0;
    wait_clk(5);
    scl = 1'b1;
    wait_clk(10);
    m_low = 1'b1;
    wait_clk(10);
    scl = 1'b0;
    wait_clk(5);
  endtask

  task automatic bus_stop();
    m_low = 1'b1;
    wait_clk(5);
    scl = 1'b1;
    wait_clk(10);
    m_low = 1'b0;
    wait_clk(10);
  endtask

  task automatic i2c_write(input logic [7:0] dev, input logic [7:0] ra, input logic [7:0] d[$],
                           output int acks);
    logic a;
    acks = 0;
    bus_start();
    send_byte(dev, a); acks += int'(a);
    send_byte(ra, a);  acks += int'(a);
    foreach (d[i]) begin
      send_byte(d[i], a);
      acks += int'(a);
    end
    bus_stop();
  endtask

  task automatic i2c_read(input logic set_ptr, input logic [7:0] ra, input int n,
                          output logic [7:0] got[$], output int acks);
    logic a;
    logic [7:0] b;
    acks = 0;
    bus_start();
    if (set_ptr) begin
      send_byte(8'h22, a); acks += int'(a);
      send_byte(ra, a);    acks += int'(a);
      bus_start();
    end
    send_byte(8'h23, a); acks += int'(a);
    for (int i = 0; i < n; i++) begin
      recv_byte(i != n - 1, b);
      got.push_back(b);
    end
    bus_stop();
  endtask

  task automatic test_reset();
    reset = 1'b1; scl = 1'b1; m_low = 1'b0; host_read_address = 8'h00;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(2);
    model_clear();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (write_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe: got %b expected 0", write_strobe); end
    total++; if (write_register_address !== 8'h00) begin bad++; $display("FAIL reset_waddr: got %h expected 00", write_register_address); end
    total++; if (write_data !== 8'h00) begin bad++; $display("FAIL reset_wdata: got %h expected 00", write_data); end
    total++; if (sda_line !== 1'b1) begin bad++; $display("FAIL reset_sda: got %b expected 1", sda_line); end
    for (int a = 0; a < 18; a++) begin
      host_read_address = 8'(a); #1;
      total++;
      if (host_read_data !== 8'h00) begin bad++; $display("FAIL reset_bank[%0d]: got %h expected 00", a, host_read_data); end
    end
  endtask

  task automatic test_single_write();
    int acks;
    logic [7:0] d[$];
    d = '{8'hA5};
    i2c_write(8'h22, 8'h03, d, acks);
    model_ptr = 8'h03; model_write(8'hA5);
    total++; if (acks !== 3) begin bad++; $display("FAIL single_acks: got %0d expected 3", acks); end
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL single_strobe_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL single_strobe_%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
    host_read_address = 8'h03; #1;
    total++; if (host_read_data !== 8'hA5) begin bad++; $display("FAIL single_host: got %h expected a5", host_read_data); end
  endtask

  task automatic test_read_back();
    logic a1, a2, a3;
    logic [7:0] b, e;
    bus_start();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL readback_busy_start: got %b expected 1", busy); end
    send_byte(8'h22, a1);
    send_byte(8'h03, a2);
    bus_start();
    send_byte(8'h23, a3);
    recv_byte(1'b0, b);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL readback_busy_nack: got %b expected 0", busy); end
    bus_stop();
    model_ptr = 8'h03; e = model_read();
    total++; if ({a1, a2, a3} !== 3'b111) begin bad++; $display("FAIL readback_acks: got %b expected 111", {a1, a2, a3}); end
    total++; if (b !== e) begin bad++; $display("FAIL readback_data: got %h expected %h", b, e); end
  endtask

  task automatic test_wrong_address();
    int acks;
    logic [7:0] d[$];
    d = '{8'h5A};
    target_low_seen = 1'b0;
    i2c_write(8'h24, 8'h03, d, acks);
    total++; if (acks !== 0) begin bad++; $display("FAIL wrong_acks: got %0d expected 0", acks); end
    total++; if (target_low_seen !== 1'b0) begin bad++; $display("FAIL wrong_sda_driven: got %b expected 0", target_low_seen); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL wrong_strobes: got %0d expected 0", got_q.size()); end
    got_q.delete();
    host_read_address = 8'h03; #1;
    total++; if (host_read_data !== model_host(8'h03)) begin bad++; $display("FAIL wrong_bank: got %h expected %h", host_read_data, model_host(8'h03)); end
  endtask

  task automatic test_burst_range_end();
    int acks;
    logic [7:0] d[$];
    d = '{8'h11, 8'h22, 8'h33};
    i2c_write(8'h22, 8'h0F, d, acks);
    model_ptr = 8'h0F;
    foreach (d[i]) model_write(d[i]);
    total++; if (acks !== 5) begin bad++; $display("FAIL burst_acks: got %0d expected 5", acks); end
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL burst_strobe_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL burst_strobe_%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
    host_read_address = 8'h0F; #1;
    total++; if (host_read_data !== 8'h11) begin bad++; $display("FAIL burst_bank15: got %h expected 11", host_read_data); end
    host_read_address = 8'h10; #1;
    total++; if (host_read_data !== 8'h00) begin bad++; $display("FAIL burst_reg10: got %h expected 00", host_read_data); end
  endtask

  task automatic test_burst_read_wrap();
    int acks;
    logic [7:0] d[$];
    logic [7:0] got[$];
    logic [7:0] e;
    d = '{8'h5C, 8'hC3};
    i2c_write(8'h22, 8'h00, d, acks);
    model_ptr = 8'h00; foreach (d[i]) model_write(d[i]);
    exp_q.delete(); got_q.delete();
    d.delete();
    i2c_write(8'h22, 8'hFF, d, acks);
    model_ptr = 8'hFF;
    total++; if (acks !== 2) begin bad++; $display("FAIL wrap_ptr_acks: got %0d expected 2", acks); end
    i2c_read(1'b0, 8'h00, 2, got, acks);
    total++; if (acks !== 1) begin bad++; $display("FAIL wrap_read_acks: got %0d expected 1", acks); end
    for (int i = 0; i < 2; i++) begin
      e = model_read();
      total++;
      if (got[i] !== e) begin bad++; $display("FAIL wrap_byte_%0d: got %h expected %h", i, got[i], e); end
    end
    got.delete();
    i2c_read(1'b0, 8'h00, 1, got, acks);
    e = model_read();
    total++; if (got[0] !== e) begin bad++; $display("FAIL wrap_ptr_end: got %h expected %h", got[0], e); end
  endtask

  task automatic test_random();
    int acks, n;
    logic [7:0] ra, e, ha;
    logic [7:0] d[$];
    logic [7:0] got[$];
    for (int it = 0; it < 10; it++) begin
      ra = 8'($urandom_range(0, 19));
      if ($urandom_range(0, 4) == 0) ra = 8'hFE;
      n = $urandom_range(1, 3);
      d.delete(); got.delete();
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < n; i++) d.push_back(8'($urandom()));
        i2c_write(8'h22, ra, d, acks);
        model_ptr = ra; foreach (d[i]) model_write(d[i]);
        total++; if (acks !== n + 2) begin bad++; $display("FAIL rand_w%0d_acks: got %0d expected %0d", it, acks, n + 2); end
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_w%0d_strobe_count: got %0d expected %0d", it, got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
          total++;
          if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_w%0d_strobe_%0d: got %h expected %h", it, i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
      end else begin
        i2c_read(1'b1, ra, n, got, acks);
        model_ptr = ra;
        total++; if (acks !== 3) begin bad++; $display("FAIL rand_r%0d_acks: got %0d expected 3", it, acks); end
        for (int i = 0; i < n; i++) begin
          e = model_read();
          total++;
          if (got[i] !== e) begin bad++; $display("FAIL rand_r%0d_byte_%0d: got %h expected %h", it, i, got[i], e); end
        end
      end
      ha = 8'($urandom_range(0, 31));
      host_read_address = ha; #1;
      total++; if (host_read_data !== model_host(ha)) begin bad++; $display("FAIL rand_host_%h: got %h expected %h", ha, host_read_data, model_host(ha)); end
    end
  endtask

  task automatic test_reset_mid_read();
    int acks;
    logic a;
    logic [7:0] d[$];
    d = '{8'h0F};
    i2c_write(8'h22, 8'h05, d, acks);
    model_ptr = 8'h05; model_write(8'h0F);
    got_q.delete(); exp_q.delete();
    bus_start();
    send_byte(8'h22, a);
    send_byte(8'h05, a);
    bus_start();
    send_byte(8'h23, a);
    total++; if (sda_line !== 1'b0) begin bad++; $display("FAIL midread_driving_zero: got %b expected 0", sda_line); end
    reset = 1'b1;
    wait_clk(1);
    total++; if (sda_line !== 1'b1) begin bad++; $display("FAIL midread_sda_released: got %b expected 1", sda_line); end
    wait_clk(2);
    reset = 1'b0;
    wait_clk(2);
    model_clear();
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL midread_strobes: got %0d expected 0", got_q.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midread_busy: got %b expected 0", busy); end
    for (int r = 0; r < 16; r++) begin
      host_read_address = 8'(r); #1;
      total++;
      if (host_read_data !== 8'h00) begin bad++; $display("FAIL midread_bank[%0d]: got %h expected 00", r, host_read_data); end
    end
    got_q.delete();
    d = '{8'h3C};
    i2c_write(8'h22, 8'h07, d, acks);
    model_ptr = 8'h07; model_write(8'h3C);
    total++; if (acks !== 3) begin bad++; $display("FAIL midread_new_acks: got %0d expected 3", acks); end
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL midread_strobe_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL midread_strobe_%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
    host_read_address = 8'h07; #1;
    total++; if (host_read_data !== 8'h3C) begin bad++; $display("FAIL midread_host: got %h expected 3c", host_read_data); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_back();
    test_wrong_address();
    test_burst_range_end();
    test_burst_read_wrap();
    test_random();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
